// File: rtl/ga_debug_pkg.sv
// ga_debug_pkg
// Shared constants and types for the GA telemetry framer: the frame start
// byte, the trigger-mode encodings, a byte-count helper and the serializer
// state encoding.
package ga_debug_pkg;

    // Frame start byte placed in front of every snapshot.
    localparam logic [7:0] HEADER_BYTE = 8'hA5;

    // Trigger modes selected by the mode input.
    localparam logic [1:0] MODE_FINISH   = 2'd0;
    localparam logic [1:0] MODE_PERIODIC = 2'd1;
    localparam logic [1:0] MODE_IMPROVE  = 2'd2;
    localparam logic [1:0] MODE_ALL      = 2'd3;

    // Number of whole bytes needed to carry a field of the given bit width.
    function automatic int bytesOf(input int width);
        return (width + 7) / 8;
    endfunction

    // Serializer progress through one frame.
    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        CHECKSUM
    } frameState_t;

endpackage

// File: rtl/ga_frame_serializer.sv
// ga_frame_serializer
// Emits one frame per accepted load: the header byte, the snapshot bytes
// MSB first, then the XOR of every byte already sent. Bytes leave through a
// valid/ready interface; txValid and txData come only from registers.
//
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   load       start a frame with snapshot (honoured in IDLE, or on the
//              checksum handshake for a back-to-back frame)
//   snapshot   payload bits, first byte in the top bits
//   txReady    sink accepts the current byte
//   txData     current frame byte
//   txValid    txData is valid
//   busy       a frame is in progress
//   done       the checksum byte is being accepted on this clock
module ga_frame_serializer
    import ga_debug_pkg::*;
#(
    parameter int         PayloadBytes = 9,
    parameter logic [7:0] Header       = HEADER_BYTE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [PayloadBytes*8-1:0] snapshot,
    input  logic                      txReady,
    output logic [7:0]                txData,
    output logic                      txValid,
    output logic                      busy,
    output logic                      done
);

    localparam int                IdxWidth = $clog2(PayloadBytes + 1);
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(PayloadBytes - 1);
    localparam int                TopBit   = PayloadBytes * 8 - 1;

    frameState_t                state;
    frameState_t                stateNext;
    logic [PayloadBytes*8-1:0]  shiftReg;
    logic [IdxWidth-1:0]        byteIdx;
    logic [7:0]                 checksum;
    logic                       handshake;
    logic                       loadAccept;

    assign handshake = txValid & txReady;
    assign txValid   = (state != IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // A new frame may start from IDLE or directly on the checksum handshake,
    // which lets a queued frame follow without a gap.
    always_comb begin
        stateNext  = state;
        done       = 1'b0;
        loadAccept = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    stateNext  = HEADER;
                    loadAccept = 1'b1;
                end
            end
            HEADER: begin
                if (handshake) begin
                    stateNext = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (handshake && byteIdx == LastIdx) begin
                    stateNext = CHECKSUM;
                end
            end
            CHECKSUM: begin
                if (handshake) begin
                    done = 1'b1;
                    if (load) begin
                        stateNext  = HEADER;
                        loadAccept = 1'b1;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        txData = 8'h00;
        case (state)
            HEADER:   txData = Header;
            PAYLOAD:  txData = shiftReg[TopBit -: 8];
            CHECKSUM: txData = checksum;
            default:  txData = 8'h00;
        endcase
    end

    // The checksum starts from the header, so after the last payload byte it
    // already covers every byte that preceded it.
    always_ff @(posedge clk) begin
        if (rst) begin
            shiftReg <= '0;
            byteIdx  <= '0;
            checksum <= 8'h00;
        end else if (loadAccept) begin
            shiftReg <= snapshot;
            byteIdx  <= '0;
            checksum <= Header;
        end else if (handshake && state == PAYLOAD) begin
            shiftReg <= shiftReg << 8;
            byteIdx  <= byteIdx + IdxWidth'(1);
            checksum <= checksum ^ shiftReg[TopBit -: 8];
        end
    end

endmodule

// File: rtl/ga_telemetry_framer.sv
// ga_telemetry_framer
// Counts GA generations and, on the selected trigger, sends a framed and
// checksummed snapshot {generation, bestError, bestIndividual} as bytes.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   cycle           one-clock pulse per completed GA generation
//   bestError       best error, valid with cycle
//   bestIndividual  best individual, valid with cycle
//   mode            0 finish-only, 1 periodic, 2 on-improvement, 3 every gen
//   period          generations between periodic reports (0 acts as 1)
//   txData/txValid  byte stream out, txReady from the sink
//   busy            a frame is in progress
//   overrun         sticky: a trigger was dropped while busy
//   finish          sticky: bestError has reached zero
module ga_telemetry_framer
    import ga_debug_pkg::*;
#(
    parameter int         IndividualWidth = 32,
    parameter int         ErrorWidth      = 5,
    parameter int         CounterWidth    = 32,
    parameter int         PeriodWidth     = 8,
    parameter logic [7:0] Header          = HEADER_BYTE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cycle,
    input  logic [ErrorWidth-1:0]      bestError,
    input  logic [IndividualWidth-1:0] bestIndividual,
    input  logic [1:0]                 mode,
    input  logic [PeriodWidth-1:0]     period,
    output logic [7:0]                 txData,
    output logic                       txValid,
    input  logic                       txReady,
    output logic                       busy,
    output logic                       overrun,
    output logic                       finish
);

    localparam int CBits    = bytesOf(CounterWidth) * 8;
    localparam int EBits    = bytesOf(ErrorWidth) * 8;
    localparam int IBits    = bytesOf(IndividualWidth) * 8;
    localparam int SnapBits = CBits + EBits + IBits;

    logic [CounterWidth-1:0] generation;
    logic [CounterWidth-1:0] genNext;
    logic [PeriodWidth-1:0]  periodCnt;
    logic [PeriodWidth:0]    periodNext;
    logic [PeriodWidth:0]    periodEff;
    logic                    periodHit;
    logic [ErrorWidth-1:0]   lastErr;
    logic                    finishPending;
    logic [SnapBits-1:0]     liveSnap;
    logic [SnapBits-1:0]     pendSnap;
    logic [SnapBits-1:0]     loadSnap;
    logic [ErrorWidth-1:0]   loadErr;
    logic                    finishTrig;
    logic                    normalTrig;
    logic                    launchLive;
    logic                    launchPend;
    logic                    load;
    logic                    serBusy;
    logic                    serDone;

    assign genNext    = generation + CounterWidth'(1);
    assign periodEff  = (period == '0) ? (PeriodWidth+1)'(1) : {1'b0, period};
    assign periodNext = {1'b0, periodCnt} + (PeriodWidth+1)'(1);
    assign periodHit  = (periodNext >= periodEff);
    assign liveSnap   = {CBits'(genNext), EBits'(bestError), IBits'(bestIndividual)};

    // Once finish is set nothing else may trigger, so the finish frame is the
    // last one sent; a zero error always wins over the mode's own trigger.
    always_comb begin
        finishTrig = cycle && !finish && (bestError == '0);
        normalTrig = 1'b0;
        if (cycle && !finish) begin
            case (mode)
                MODE_PERIODIC: normalTrig = periodHit;
                MODE_IMPROVE:  normalTrig = (bestError < lastErr);
                MODE_ALL:      normalTrig = 1'b1;
                default:       normalTrig = 1'b0;
            endcase
        end
    end

    // A finish trigger arriving on the checksum handshake is launched straight
    // into the back-to-back slot rather than parked, so it can never be lost.
    // The parked finish snapshot always carries a zero error.
    always_comb begin
        launchLive = ((finishTrig || normalTrig) && !serBusy) || (serDone && finishTrig);
        launchPend = serDone && finishPending;
        load       = launchLive || launchPend;
        loadSnap   = launchPend ? pendSnap : liveSnap;
        loadErr    = launchPend ? '0 : bestError;
    end

    // Counters, sticky flags and the parked finish snapshot. The periodic
    // counter only runs while periodic mode is selected.
    always_ff @(posedge clk) begin
        if (rst) begin
            generation    <= '0;
            periodCnt     <= '0;
            lastErr       <= '1;
            finishPending <= 1'b0;
            pendSnap      <= '0;
            overrun       <= 1'b0;
            finish        <= 1'b0;
        end else begin
            if (cycle) begin
                generation <= genNext;
                if (mode == MODE_PERIODIC) begin
                    periodCnt <= periodHit ? '0 : periodNext[PeriodWidth-1:0];
                end else begin
                    periodCnt <= '0;
                end
            end
            if (finishTrig) begin
                finish <= 1'b1;
            end
            if (serBusy && finishTrig && !serDone) begin
                pendSnap      <= liveSnap;
                finishPending <= 1'b1;
            end else if (launchPend) begin
                finishPending <= 1'b0;
            end
            if (serBusy && normalTrig && !finishTrig) begin
                overrun <= 1'b1;
            end
            if (load) begin
                lastErr <= loadErr;
            end
        end
    end

    ga_frame_serializer #(
        .PayloadBytes(SnapBits / 8),
        .Header      (Header)
    ) serializer (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .snapshot(loadSnap),
        .txReady (txReady),
        .txData  (txData),
        .txValid (txValid),
        .busy    (serBusy),
        .done    (serDone)
    );

    assign busy = serBusy;

endmodule

// File: tb/tb_ga_telemetry_framer.sv
// tb_ga_telemetry_framer
// Drives the framer with directed scenarios and random traffic and checks
// every clock against a transaction-level model that keeps the bytes each
// frame still owes the sink.
module tb_ga_telemetry_framer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cycle = 1'b0;
    logic [4:0]  bestError = 5'd0;
    logic [31:0] bestIndividual = 32'd0;
    logic [1:0]  mode = 2'd3;
    logic [7:0]  period = 8'd1;
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady = 1'b1;
    logic        busy;
    logic        overrun;
    logic        finish;

    int nChecks = 0;
    int nFails  = 0;
    int cycleNo = 0;

    typedef logic [7:0] byteQ_t[$];

    // Model state.
    byteQ_t      curQ;
    byteQ_t      pendQ;
    logic [31:0] mGen;
    int          mPer;
    logic [4:0]  mLastErr;
    bit          mFinish;
    bit          mPend;
    bit          mOverrun;
    bit          modelReady = 1'b0;
    bit          wasBusy;
    bit          isFin;
    bit          isNorm;

    // Bytes seen on the sink side and the clock on which each was accepted.
    byteQ_t      capLog;
    int          capStamp[$];

    logic [7:0] expT1 [11] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 8'h05,
                               8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h83};

    ga_telemetry_framer dut (
        .clk           (clk),
        .rst           (rst),
        .cycle         (cycle),
        .bestError     (bestError),
        .bestIndividual(bestIndividual),
        .mode          (mode),
        .period        (period),
        .txData        (txData),
        .txValid       (txValid),
        .txReady       (txReady),
        .busy          (busy),
        .overrun       (overrun),
        .finish        (finish)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleNo <= cycleNo + 1;

    // Whole frame as the sink must see it for one snapshot.
    function automatic byteQ_t buildFrame(logic [31:0] g, logic [4:0] e, logic [31:0] ind);
        byteQ_t     f;
        logic [7:0] x;
        f.push_back(8'hA5);
        for (int i = 3; i >= 0; i--) f.push_back(g[i*8 +: 8]);
        f.push_back({3'b000, e});
        for (int i = 3; i >= 0; i--) f.push_back(ind[i*8 +: 8]);
        x = 8'h00;
        foreach (f[i]) x = x ^ f[i];
        f.push_back(x);
        return f;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (clk %0d)", name, actual, expected, cycleNo);
        end
    endtask

    // Transaction-level reference: one byte leaves per accepted handshake, a
    // trigger while bytes remain is dropped (or parked if it is the finish).
    always @(posedge clk) begin
        if (rst) begin
            mGen = 32'd0;
            mPer = 0;
            mLastErr = 5'h1f;
            mFinish = 1'b0;
            mPend = 1'b0;
            mOverrun = 1'b0;
            curQ.delete();
            pendQ.delete();
            modelReady = 1'b1;
        end else if (modelReady) begin
            wasBusy = (curQ.size() != 0);
            if (wasBusy && txReady) void'(curQ.pop_front());
            if (cycle) begin
                mGen = mGen + 32'd1;
                isFin = (bestError == 5'd0) && !mFinish;
                isNorm = 1'b0;
                if (mode == 2'd1) begin
                    mPer++;
                    if (mPer >= ((period == 8'd0) ? 1 : int'(period))) begin
                        mPer = 0;
                        isNorm = !mFinish;
                    end
                end else begin
                    mPer = 0;
                end
                if (!mFinish && mode == 2'd2 && bestError < mLastErr) isNorm = 1'b1;
                if (!mFinish && mode == 2'd3) isNorm = 1'b1;
                if (isFin) mFinish = 1'b1;
                if (isFin || isNorm) begin
                    if (!wasBusy) begin
                        curQ = buildFrame(mGen, bestError, bestIndividual);
                        mLastErr = bestError;
                    end else if (isFin) begin
                        pendQ = buildFrame(mGen, bestError, bestIndividual);
                        mPend = 1'b1;
                    end else begin
                        mOverrun = 1'b1;
                    end
                end
            end
            if (wasBusy && curQ.size() == 0 && mPend) begin
                curQ = pendQ;
                mPend = 1'b0;
                mLastErr = 5'd0;
            end
        end
    end

    // Compare on the falling edge, where every output is settled.
    always @(negedge clk) begin
        if (modelReady) begin
            checkOutput("txValid", txValid, curQ.size() != 0);
            checkOutput("busy", busy, curQ.size() != 0);
            checkOutput("overrun", overrun, mOverrun);
            checkOutput("finish", finish, mFinish);
            if (curQ.size() != 0) checkOutput("txData", txData, curQ[0]);
            if (txValid && txReady) begin
                capLog.push_back(txData);
                capStamp.push_back(cycleNo);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        cycle = 1'b0;
        txReady = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        capLog.delete();
        capStamp.delete();
    endtask

    task automatic applyStimulus(input logic [4:0] err, input logic [31:0] ind);
        bestError = err;
        bestIndividual = ind;
        cycle = 1'b1;
        tick();
        cycle = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        checkOutput("idleReached", busy, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        byteQ_t ref1;
        int     n;

        // Model pin: A5^01^05^DE^AD^BE^EF = 83.
        ref1 = buildFrame(32'd1, 5'd5, 32'hDEADBEEF);
        checkOutput("modelChecksum", ref1[10], 8'h83);

        // Single frame in every-generation mode.
        resetDut();
        checkOutput("resetTxData", txData, 8'h00);
        checkOutput("resetTxValid", txValid, 0);
        mode = 2'd3;
        applyStimulus(5'd5, 32'hDEADBEEF);
        waitIdle(40);
        checkOutput("t1Length", capLog.size(), 11);
        for (int i = 0; i < 11; i++)
            if (i < capLog.size()) checkOutput($sformatf("t1Byte%0d", i), capLog[i], expT1[i]);

        // Periodic every third generation.
        resetDut();
        mode = 2'd1;
        period = 8'd3;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(5'd9, 32'h1000 + i);
            idle(19);
        end
        checkOutput("t2Length", capLog.size(), 33);
        if (capLog.size() >= 33) begin
            checkOutput("t2Gen0", capLog[4], 3);
            checkOutput("t2Gen1", capLog[15], 6);
            checkOutput("t2Gen2", capLog[26], 9);
        end
        checkOutput("t2Overrun", overrun, 0);

        // On improvement only.
        resetDut();
        mode = 2'd2;
        foreach (expT1[i]) if (i < 5) begin
            case (i)
                0: applyStimulus(5'd7, 32'hA);
                1: applyStimulus(5'd7, 32'hB);
                2: applyStimulus(5'd4, 32'hC);
                3: applyStimulus(5'd6, 32'hD);
                default: applyStimulus(5'd2, 32'hE);
            endcase
            idle(19);
        end
        checkOutput("t3Length", capLog.size(), 33);
        if (capLog.size() >= 33) begin
            checkOutput("t3Err0", capLog[5], 7);
            checkOutput("t3Err1", capLog[16], 4);
            checkOutput("t3Err2", capLog[27], 2);
            checkOutput("t3Gen1", capLog[15], 3);
            checkOutput("t3Gen2", capLog[26], 5);
        end

        // Back-pressure: sink stalls, second trigger is dropped.
        resetDut();
        mode = 2'd3;
        txReady = 1'b0;
        applyStimulus(5'd8, 32'h12345678);
        idle(4);
        applyStimulus(5'd6, 32'h9ABCDEF0);
        idle(44);
        checkOutput("t4StallValid", txValid, 1);
        checkOutput("t4StallData", txData, 8'hA5);
        checkOutput("t4Overrun", overrun, 1);
        txReady = 1'b1;
        waitIdle(40);
        idle(5);
        checkOutput("t4Length", capLog.size(), 11);
        if (capLog.size() >= 11) checkOutput("t4Gen", capLog[4], 1);

        // Finish arrives mid-frame and follows back-to-back.
        resetDut();
        mode = 2'd3;
        applyStimulus(5'd9, 32'h0BADF00D);
        idle(2);
        mode = 2'd0;
        applyStimulus(5'd0, 32'hCAFEF00D);
        waitIdle(60);
        checkOutput("t5Length", capLog.size(), 22);
        checkOutput("t5Finish", finish, 1);
        if (capLog.size() >= 22) begin
            checkOutput("t5Header2", capLog[11], 8'hA5);
            checkOutput("t5Gap", capStamp[11] - capStamp[10], 1);
            checkOutput("t5Gen2", capLog[15], 2);
            checkOutput("t5Err2", capLog[16], 0);
        end
        mode = 2'd3;
        applyStimulus(5'd3, 32'h1);
        idle(3);
        applyStimulus(5'd0, 32'h2);
        idle(20);
        checkOutput("t5After", capLog.size(), 22);
        checkOutput("t5NoOverrun", overrun, 0);

        // Reset in the middle of the payload.
        resetDut();
        mode = 2'd3;
        applyStimulus(5'd4, 32'h55AA55AA);
        idle(1);
        applyStimulus(5'd3, 32'h1);
        n = 0;
        while (capLog.size() < 5 && n < 40) begin
            tick();
            n++;
        end
        checkOutput("t6ReachByte4", capLog.size() >= 5, 1);
        checkOutput("t6PreOverrun", overrun, 1);
        rst = 1'b1;
        tick();
        checkOutput("t6RstValid", txValid, 0);
        checkOutput("t6RstBusy", busy, 0);
        checkOutput("t6RstOverrun", overrun, 0);
        rst = 1'b0;
        capLog.delete();
        capStamp.delete();
        applyStimulus(5'd5, 32'h77);
        waitIdle(40);
        checkOutput("t6Length", capLog.size(), 11);
        if (capLog.size() >= 11) checkOutput("t6Gen", capLog[4], 1);

        // Random traffic across all modes with a jittery sink.
        for (int s = 0; s < 6; s++) begin
            resetDut();
            mode = 2'($urandom_range(0, 3));
            period = 8'($urandom_range(0, 4));
            for (int c = 0; c < 300; c++) begin
                bestError = ($urandom_range(0, 25) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                bestIndividual = $urandom;
                cycle = ($urandom_range(0, 4) == 0);
                txReady = ($urandom_range(0, 3) != 0);
                tick();
            end
            cycle = 1'b0;
            txReady = 1'b1;
            waitIdle(60);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
